// File: rtl/img_rsz_pxl_fwd_pkg.sv
// ImgRszPkg: shared sizes, types and helpers for the resizer forward end
// Holds the pixel/colour/image/block-size parameters, the accumulator and pixel array types,
// the forward FSM state enum, and the leading-one / block-size-check helpers.
package ImgRszPkg;
  localparam int PXL_PRIM_COLOR_NUM = 3;
  localparam int PXL_PRIM_COLOR_W = 8;
  localparam int RSZ_IMG_WIDTH_SIZE = 64;
  localparam int RSZ_IMG_HEIGHT_SIZE = 64;
  localparam int BLK_WIDTH_MAX_SZ_W = 5;
  localparam int BLK_HEIGHT_MAX_SZ_W = 5;
  localparam int ACC_W = PXL_PRIM_COLOR_W + BLK_WIDTH_MAX_SZ_W + BLK_HEIGHT_MAX_SZ_W;
  localparam int RSZ_IMG_WIDTH_IDX_W = $clog2(RSZ_IMG_WIDTH_SIZE);
  localparam int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE);
  localparam int BLK_SZ_MAX_W = BLK_WIDTH_MAX_SZ_W > BLK_HEIGHT_MAX_SZ_W ? BLK_WIDTH_MAX_SZ_W : BLK_HEIGHT_MAX_SZ_W;
  localparam int SH_LOD_W = $clog2(BLK_SZ_MAX_W);
  localparam int SH_W = SH_LOD_W + 1;
  localparam logic [RSZ_IMG_WIDTH_IDX_W-1:0] RSZ_X_LAST = RSZ_IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
  localparam logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RSZ_Y_LAST = RSZ_IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1);
  typedef logic [ACC_W-1:0] RszAccData_t [PXL_PRIM_COLOR_NUM-1:0];
  typedef logic [PXL_PRIM_COLOR_W-1:0] RszPxlData_t [PXL_PRIM_COLOR_NUM-1:0];
  typedef enum logic {FWD_IDLE, FWD_RUN} FwdState_e;
  // Position of the highest set bit; 0 for a zero input.
  function automatic logic [SH_LOD_W-1:0] lodPos(input logic [BLK_SZ_MAX_W-1:0] v);
    lodPos = '0;
    for (int i = 0; i < BLK_SZ_MAX_W; i++) if (v[i]) lodPos = SH_LOD_W'(i);
  endfunction
  function automatic logic szBad(input logic [BLK_SZ_MAX_W-1:0] v);
    return (v == '0) | (|(v & (v - 1'b1)));
  endfunction
endpackage

// File: rtl/img_rsz_pxl_fwd_if.sv
// img_rsz_pxl_fwd_if: block-size load, accumulator stream and resized pixel stream
// master = block-size/accumulator producer and pixel consumer; slave = the forward end.
interface img_rsz_pxl_fwd_if;
  import ImgRszPkg::*;
  logic BlkSzLd;
  logic [BLK_WIDTH_MAX_SZ_W-1:0] BlkSzHor;
  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer;
  RszAccData_t AccData;
  logic AccVld;
  logic AccRdy;
  RszPxlData_t RszPxlData;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0] RszPxlX;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RszPxlY;
  logic RszPxlLast;
  logic RszPxlVld;
  logic RszPxlRdy;
  logic FwdRszEn;
  logic BlkSzErr;
  modport master(
    output BlkSzLd, BlkSzHor, BlkSzVer, AccData, AccVld, RszPxlRdy,
    input AccRdy, RszPxlData, RszPxlX, RszPxlY, RszPxlLast, RszPxlVld, FwdRszEn, BlkSzErr
  );
  modport slave(
    input BlkSzLd, BlkSzHor, BlkSzVer, AccData, AccVld, RszPxlRdy,
    output AccRdy, RszPxlData, RszPxlX, RszPxlY, RszPxlLast, RszPxlVld, FwdRszEn, BlkSzErr
  );
endinterface

// File: rtl/img_rsz_blk_avg.sv
// img_rsz_blk_avg: divides one colour block sum by 2^Sh with round-half-up and saturation
// Ports: AccData (block sum), Sh (total shift), Avg (averaged colour component).
module img_rsz_blk_avg
  import ImgRszPkg::*;
(
  input  logic [ACC_W-1:0]            AccData,
  input  logic [SH_W-1:0]             Sh,
  output logic [PXL_PRIM_COLOR_W-1:0] Avg
);
  // One extra bit so adding the rounding half never overflows.
  logic [ACC_W:0] rnd;
  logic [ACC_W:0] quo;
  always_comb begin
    rnd = (Sh == '0) ? '0 : (ACC_W + 1)'(1) << (Sh - 1'b1);
    quo = ({1'b0, AccData} + rnd) >> Sh;
    Avg = (|quo[ACC_W:PXL_PRIM_COLOR_W]) ? '1 : quo[PXL_PRIM_COLOR_W-1:0];
  end
endmodule

// File: rtl/img_rsz_pxl_fwd.sv
// img_rsz_pxl_fwd: averages block sums into resized pixels and streams them out with X/Y/last
// Ports: Clk, Reset (sync, active-high), Bus (slave side: block-size load, accumulator
// valid/ready input, resized pixel valid/ready output, FwdRszEn loop-back pulse, sticky BlkSzErr).
module img_rsz_pxl_fwd
  import ImgRszPkg::*;
(
  input logic               Clk,
  input logic               Reset,
  img_rsz_pxl_fwd_if.slave  Bus
);
  FwdState_e state;
  logic [SH_LOD_W-1:0] shH;
  logic [SH_LOD_W-1:0] shV;
  logic [SH_W-1:0] sh;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0] xCnt;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] yCnt;
  RszPxlData_t avgData;
  logic fwd;
  logic accept;
  logic ldNow;
  assign sh = SH_W'(shH) + SH_W'(shV);
  assign fwd = Bus.RszPxlVld & Bus.RszPxlRdy;
  assign Bus.FwdRszEn = fwd;
  assign Bus.AccRdy = (state == FWD_RUN) & (~Bus.RszPxlVld | Bus.RszPxlRdy);
  assign accept = Bus.AccVld & Bus.AccRdy;
  // A new size is taken only between images: when idle, or as the last pixel leaves.
  assign ldNow = Bus.BlkSzLd & ((state == FWD_IDLE) | (fwd & Bus.RszPxlLast));
  for (genvar c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin : gAvg
    img_rsz_blk_avg uAvg (.AccData(Bus.AccData[c]), .Sh(sh), .Avg(avgData[c]));
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FWD_IDLE;
      shH <= '0;
      shV <= '0;
      xCnt <= '0;
      yCnt <= '0;
      Bus.BlkSzErr <= 1'b0;
      Bus.RszPxlVld <= 1'b0;
      Bus.RszPxlX <= '0;
      Bus.RszPxlY <= '0;
      Bus.RszPxlLast <= 1'b0;
      Bus.RszPxlData <= '{default: '0};
    end else begin
      if (ldNow) begin
        state <= FWD_RUN;
        shH <= lodPos(BLK_SZ_MAX_W'(Bus.BlkSzHor));
        shV <= lodPos(BLK_SZ_MAX_W'(Bus.BlkSzVer));
        Bus.BlkSzErr <= Bus.BlkSzErr | szBad(BLK_SZ_MAX_W'(Bus.BlkSzHor)) | szBad(BLK_SZ_MAX_W'(Bus.BlkSzVer));
      end else if (fwd & Bus.RszPxlLast) begin
        state <= FWD_IDLE;
      end
      if (accept) begin
        Bus.RszPxlData <= avgData;
        Bus.RszPxlX <= xCnt;
        Bus.RszPxlY <= yCnt;
        Bus.RszPxlLast <= (xCnt == RSZ_X_LAST) & (yCnt == RSZ_Y_LAST);
        Bus.RszPxlVld <= 1'b1;
        xCnt <= (xCnt == RSZ_X_LAST) ? '0 : xCnt + 1'b1;
        if (xCnt == RSZ_X_LAST) yCnt <= (yCnt == RSZ_Y_LAST) ? '0 : yCnt + 1'b1;
      end else if (fwd) begin
        Bus.RszPxlVld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// tb_img_rsz_pxl_fwd: randomized bench for img_rsz_pxl_fwd against a queue-based pixel model
module tb_img_rsz_pxl_fwd;
  import ImgRszPkg::*;
  localparam int PW = PXL_PRIM_COLOR_W;
  localparam int NC = PXL_PRIM_COLOR_NUM;
  localparam int IMG_PIX = RSZ_IMG_WIDTH_SIZE * RSZ_IMG_HEIGHT_SIZE;
  typedef struct packed {
    logic [NC*PW-1:0] d;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0] x;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] y;
    logic last;
  } Pxl_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  img_rsz_pxl_fwd_if bus();
  img_rsz_pxl_fwd dut (.Clk(Clk), .Reset(Reset), .Bus(bus.slave));
  always #5 Clk = ~Clk;
  Pxl_t q[$];
  bit run, expErr;
  int pixN, hor, ver;
  int accIn[NC];
  int nVec = 0, nErr = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lg2(input int v);
    int k = 0;
    while ((2 << k) <= v) k++;
    return k;
  endfunction
  // Block mean of s over area a, rounded half up, clipped to the colour range.
  function automatic int avgRef(input int s, input int a);
    int r = (2 * s + a) / (2 * a);
    return r > (1 << PW) - 1 ? (1 << PW) - 1 : r;
  endfunction
  task automatic randAcc();
    int lim = 260 << (lg2(hor) + lg2(ver));
    if (lim > (1 << ACC_W) - 1 || $urandom_range(0, 7) == 0) lim = (1 << ACC_W) - 1;
    for (int c = 0; c < NC; c++) accIn[c] = $urandom_range(0, lim);
  endtask
  task automatic doReset(input bit vld);
    logic [NC*PW-1:0] got;
    Reset = 1'b1;
    bus.BlkSzLd = 1'b0;
    bus.AccVld = vld;
    bus.RszPxlRdy = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    q.delete();
    run = 0;
    expErr = 0;
    pixN = 0;
    #1;
    for (int c = 0; c < NC; c++) got[c*PW +: PW] = bus.RszPxlData[c];
    chk("rst RszPxlVld", 64'(bus.RszPxlVld), 64'(0));
    chk("rst RszPxlX", 64'(bus.RszPxlX), 64'(0));
    chk("rst RszPxlY", 64'(bus.RszPxlY), 64'(0));
    chk("rst RszPxlLast", 64'(bus.RszPxlLast), 64'(0));
    chk("rst RszPxlData", 64'(got), 64'(0));
    chk("rst BlkSzErr", 64'(bus.BlkSzErr), 64'(0));
    chk("rst AccRdy", 64'(bus.AccRdy), 64'(0));
  endtask
  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit ld, input int h, input int v, input bit vld, input bit rdy);
    Pxl_t p;
    logic [NC*PW-1:0] got;
    bit expVld, expRdy, fwd, acc, loadNow;
    bus.BlkSzLd = ld;
    bus.BlkSzHor = BLK_WIDTH_MAX_SZ_W'(h);
    bus.BlkSzVer = BLK_HEIGHT_MAX_SZ_W'(v);
    for (int c = 0; c < NC; c++) bus.AccData[c] = ACC_W'(accIn[c]);
    bus.AccVld = vld;
    bus.RszPxlRdy = rdy;
    #1;
    expVld = q.size() != 0;
    expRdy = run && (!expVld || rdy);
    chk("AccRdy", 64'(bus.AccRdy), 64'(expRdy));
    chk("RszPxlVld", 64'(bus.RszPxlVld), 64'(expVld));
    chk("FwdRszEn", 64'(bus.FwdRszEn), 64'(expVld && rdy));
    chk("BlkSzErr", 64'(bus.BlkSzErr), 64'(expErr));
    if (expVld) begin
      for (int c = 0; c < NC; c++) got[c*PW +: PW] = bus.RszPxlData[c];
      chk("RszPxlData", 64'(got), 64'(q[0].d));
      chk("RszPxlX", 64'(bus.RszPxlX), 64'(q[0].x));
      chk("RszPxlY", 64'(bus.RszPxlY), 64'(q[0].y));
      chk("RszPxlLast", 64'(bus.RszPxlLast), 64'(q[0].last));
    end
    fwd = expVld && rdy;
    acc = vld && expRdy;
    loadNow = ld && (!run || (fwd && q[0].last));
    p = '0;
    if (acc) begin
      for (int c = 0; c < NC; c++) p.d[c*PW +: PW] = PW'(avgRef(accIn[c], 1 << (lg2(hor) + lg2(ver))));
      p.x = RSZ_IMG_WIDTH_IDX_W'(pixN % RSZ_IMG_WIDTH_SIZE);
      p.y = RSZ_IMG_HEIGHT_IDX_W'(pixN / RSZ_IMG_WIDTH_SIZE);
      p.last = pixN == IMG_PIX - 1;
      pixN = (pixN + 1) % IMG_PIX;
    end
    if (fwd) begin
      if (q[0].last) run = 0;
      void'(q.pop_front());
    end
    if (acc) q.push_back(p);
    if (loadNow) begin
      run = 1;
      hor = h;
      ver = v;
      if (h == 0 || v == 0 || (h & (h - 1)) != 0 || (v & (v - 1)) != 0) expErr = 1;
    end
    @(posedge Clk);
    #1;
  endtask
  function automatic int randSz();
    return $urandom_range(0, 9) < 7 ? 1 << $urandom_range(0, 4) : int'($urandom_range(0, 31));
  endfunction
  initial begin
    hor = 1;
    ver = 1;
    for (int c = 0; c < NC; c++) accIn[c] = 0;
    @(posedge Clk);
    #1;
    doReset(1'b0);
    for (int i = 0; i < 10; i++) begin
      randAcc();
      step(0, 0, 0, 1, 1);
    end
    doReset(1'b0);
    step(1, 4, 4, 0, 0);
    accIn[2] = 255 * 16; accIn[1] = 128 * 16; accIn[0] = 0;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    doReset(1'b0);
    step(1, 2, 2, 0, 1);
    accIn[0] = 6; accIn[1] = 5; accIn[2] = 2;
    step(0, 0, 0, 1, 1);
    accIn[0] = 5; accIn[1] = 7; accIn[2] = 1;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    doReset(1'b0);
    step(1, 1, 1, 0, 1);
    accIn[0] = 300; accIn[1] = 255; accIn[2] = (1 << ACC_W) - 1;
    step(0, 0, 0, 1, 1);
    accIn[0] = 0; accIn[1] = 1; accIn[2] = 254;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    doReset(1'b0);
    step(1, 3, 1, 0, 1);
    accIn[0] = 5; accIn[1] = 4; accIn[2] = 3;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    doReset(1'b0);
    step(1, 4, 4, 0, 1);
    for (int i = 0; i < IMG_PIX; i++) begin
      randAcc();
      step(0, 0, 0, 1, 1);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 8, 2, 0, 1);
    for (int i = 0; i < 14000; i++) begin
      randAcc();
      step($urandom_range(0, 9) == 0, randSz(), randSz(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end
    doReset(1'b0);
    step(1, 2, 4, 0, 1);
    for (int i = 0; i < 100; i++) begin
      randAcc();
      step(0, 0, 0, 1, $urandom_range(0, 1));
    end
    doReset(1'b1);
    for (int i = 0; i < 4; i++) begin
      randAcc();
      step(0, 0, 0, 1, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
